// File: rtl/divisor_secuencial.sv
// divisor_secuencial: 8-bit by 4-bit signed restoring divider, one quotient bit per cycle
// Ports: clk_i clock; reset_i sync active-low reset; inicio_i start (IDLE only);
//        dividendo_i 8-bit signed; divisor_i 4-bit signed; result_o {rem[3:0], quo[3:0]};
//        listo_o one-cycle done; ocupado_o busy; div_cero_o divide by zero; desborde_o quotient overflow
module divisor_secuencial (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       inicio_i,
  input  logic [7:0] dividendo_i,
  input  logic [3:0] divisor_i,
  output logic [7:0] result_o,
  output logic       listo_o,
  output logic       ocupado_o,
  output logic       div_cero_o,
  output logic       desborde_o
);
  typedef enum logic [2:0] {IDLE = 3'd0, CARGA = 3'd1, ITER = 3'd2, AJUSTE = 3'd3, FIN = 3'd4} state_t;
  state_t state_q, state_d;
  logic [7:0] dvd_q, dvd_d, mag_q, mag_d, rem_q, rem_d, res_q, res_d;
  logic [3:0] dvs_q, dvs_d, dmag_q, dmag_d, rem_s;
  logic [2:0] cnt_q, cnt_d;
  logic       sd_q, sd_d, sv_q, sv_d, dz_q, dz_d, ovf_q, ovf_d, ge;
  logic [8:0] rem_sh, quo_s;
  // mag_q holds |dividend| and shifts the quotient in from the right as dividend bits leave
  assign rem_sh = {rem_q, mag_q[7]};
  assign ge     = rem_sh >= {5'b0, dmag_q};
  assign quo_s  = (sd_q ^ sv_q) ? 9'(-{1'b0, mag_q}) : {1'b0, mag_q};
  assign rem_s  = sd_q ? 4'(-rem_q[3:0]) : rem_q[3:0];
  always_comb begin
    state_d = state_q;
    dvd_d = dvd_q;
    dvs_d = dvs_q;
    mag_d = mag_q;
    dmag_d = dmag_q;
    rem_d = rem_q;
    cnt_d = cnt_q;
    sd_d = sd_q;
    sv_d = sv_q;
    res_d = res_q;
    dz_d = dz_q;
    ovf_d = ovf_q;
    case (state_q)
      IDLE: if (inicio_i) begin
        state_d = CARGA;
        dvd_d = dividendo_i;
        dvs_d = divisor_i;
      end
      CARGA: begin
        sd_d = dvd_q[7];
        sv_d = dvs_q[3];
        mag_d = dvd_q[7] ? 8'(-dvd_q) : dvd_q;
        dmag_d = dvs_q[3] ? 4'(-dvs_q) : dvs_q;
        rem_d = 8'h00;
        cnt_d = 3'd0;
        // zero divisor skips the iterations; AJUSTE publishes the flag so it appears with listo
        state_d = (dvs_q == 4'h0) ? AJUSTE : ITER;
      end
      ITER: begin
        rem_d = ge ? 8'(rem_sh - {5'b0, dmag_q}) : rem_sh[7:0];
        mag_d = {mag_q[6:0], ge};
        cnt_d = cnt_q + 3'd1;
        state_d = (cnt_q == 3'd7) ? AJUSTE : ITER;
      end
      AJUSTE: begin
        state_d = FIN;
        dz_d = dmag_q == 4'h0;
        // overflow when the 9-bit signed quotient is not a sign extension of its low 4 bits
        ovf_d = !dz_d && (quo_s[8:3] != 6'h00) && (quo_s[8:3] != 6'h3F);
        res_d = dz_d ? 8'h00 : {rem_s, quo_s[3:0]};
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      dvd_q <= '0;
      dvs_q <= '0;
      mag_q <= '0;
      dmag_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      sd_q <= 1'b0;
      sv_q <= 1'b0;
      res_q <= '0;
      dz_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q <= dvd_d;
      dvs_q <= dvs_d;
      mag_q <= mag_d;
      dmag_q <= dmag_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
      sd_q <= sd_d;
      sv_q <= sv_d;
      res_q <= res_d;
      dz_q <= dz_d;
      ovf_q <= ovf_d;
    end
  end
  assign result_o   = res_q;
  assign listo_o    = state_q == FIN;
  assign ocupado_o  = state_q != IDLE;
  assign div_cero_o = dz_q;
  assign desborde_o = ovf_q;
endmodule
